// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch mode controller: state codes, blink
// field positions and the tick rate every timing parameter is derived from.
package stopwatch_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_SET   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int BLINK_XX = 0;
    localparam int BLINK_SS = 1;
    localparam int BLINK_MM = 2;
    localparam int BLINK_HH = 3;

    localparam int TICK_RATE_HZ = 100;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    function automatic logic [3:0] field_bit(input int idx);
        return 4'b0001 << idx;
    endfunction

    localparam logic [3:0] BLINK_ALL = field_bit(BLINK_XX) | field_bit(BLINK_SS) |
                                       field_bit(BLINK_MM) | field_bit(BLINK_HH);

endpackage

// File: rtl/stopwatch_ctrl_hold_repeat.sv
// Press-and-hold auto-repeat for one set button: first repeat after
// REPEAT_DELAY ticks of continuous hold, then one every REPEAT_RATE ticks.
module hold_repeat
    import stopwatch_pkg::*;
#(
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic active,
    output logic rep
);

    localparam int HW = cnt_width(REPEAT_DELAY);
    localparam logic [HW-1:0] DELAY_V  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] RELOAD_V = HW'(REPEAT_DELAY - REPEAT_RATE);

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_inc;

    assign hold_inc = hold_cnt + HW'(1);
    assign rep      = active && tick && (hold_inc == DELAY_V);

    // Reloading to DELAY-RATE after each repeat gives the steady repeat period.
    always_ff @(posedge clk) begin
        if (rst || !active)
            hold_cnt <= '0;
        else if (tick)
            hold_cnt <= (hold_inc == DELAY_V) ? RELOAD_V : hold_inc;
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: turns debounced buttons and the 100 Hz tick into
// counter strobes, set increments, countdown alarm and display blink masks.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int REPEAT_DELAY = TICK_RATE_HZ / 2,
    parameter int REPEAT_RATE  = TICK_RATE_HZ / 10,
    parameter int SET_TIMEOUT  = TICK_RATE_HZ * 10,
    parameter int ALARM_TICKS  = TICK_RATE_HZ * 3,
    parameter int BLINK_HALF   = TICK_RATE_HZ / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_100hz,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_set_min,
    input  logic       btn_set_hour,
    input  logic       countdown_sw,
    input  logic       time_zero,
    output logic       cnt_en,
    output logic       cnt_dir,
    output logic       cnt_clr,
    output logic       inc_min,
    output logic       inc_hour,
    output logic [2:0] state,
    output logic [3:0] blink_mask,
    output logic       alarm
);

    localparam int TW = cnt_width(SET_TIMEOUT);
    localparam int AW = cnt_width(ALARM_TICKS);
    localparam int BW = cnt_width(BLINK_HALF);
    localparam logic [TW-1:0] TMO_V   = TW'(SET_TIMEOUT);
    localparam logic [AW-1:0] ALARM_V = AW'(ALARM_TICKS);
    localparam logic [BW-1:0] BLINK_V = BW'(BLINK_HALF);

    // Buttons are sampled once, then compared against the previous sample.
    logic [3:0] btn_s, btn_q;
    logic       rise_start, rise_stop, rise_min, rise_hour, any_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s <= '0;
            btn_q <= '0;
        end else begin
            btn_s <= {btn_set_hour, btn_set_min, btn_stop, btn_start};
            btn_q <= btn_s;
        end
    end

    assign {rise_hour, rise_min, rise_stop, rise_start} = btn_s & ~btn_q;
    assign any_rise = rise_hour | rise_min | rise_stop | rise_start;

    logic active_min, active_hour, rep_min, rep_hour;

    assign active_min  = (state == ST_SET) && btn_s[2] && !btn_s[3];
    assign active_hour = (state == ST_SET) && btn_s[3] && !btn_s[2];

    hold_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_min (
        .clk(clk), .rst(rst), .tick(tick_100hz), .active(active_min), .rep(rep_min)
    );

    hold_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_hour (
        .clk(clk), .rst(rst), .tick(tick_100hz), .active(active_hour), .rep(rep_hour)
    );

    logic [TW-1:0] tmo_cnt;
    logic [AW-1:0] alarm_cnt;
    logic [BW-1:0] blink_cnt, blink_nxt;
    logic          phase, phase_nxt, last_hour;
    logic          start_ok, expire, tmo_clr, tmo_hit, alarm_hit;
    logic [2:0]    state_nxt;

    assign start_ok  = !(countdown_sw && time_zero);
    assign expire    = tick_100hz && cnt_dir && time_zero;
    assign tmo_clr   = any_rise || rep_min || rep_hour;
    assign tmo_hit   = tick_100hz && !tmo_clr && (tmo_cnt + TW'(1) == TMO_V);
    assign alarm_hit = tick_100hz && (alarm_cnt + AW'(1) == ALARM_V);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Stop outranks start everywhere; expiry outranks stop in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rise_stop)
                    state_nxt = ST_IDLE;
                else if (rise_start)
                    state_nxt = start_ok ? ST_RUN : ST_IDLE;
                else if (rise_min || rise_hour)
                    state_nxt = ST_SET;
            end
            ST_RUN: begin
                if (expire)
                    state_nxt = ST_DONE;
                else if (rise_stop)
                    state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (rise_stop)
                    state_nxt = ST_IDLE;
                else if (rise_start)
                    state_nxt = ST_RUN;
                else if (rise_min || rise_hour)
                    state_nxt = ST_SET;
            end
            ST_SET: begin
                if (rise_stop)
                    state_nxt = ST_IDLE;
                else if (rise_start && start_ok)
                    state_nxt = ST_RUN;
                else if (tmo_hit)
                    state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                if (any_rise || alarm_hit)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        phase_nxt = phase;
        blink_nxt = blink_cnt;
        if (state_nxt != state) begin
            phase_nxt = 1'b0;
            blink_nxt = '0;
        end else if (tick_100hz) begin
            if (blink_cnt + BW'(1) == BLINK_V) begin
                blink_nxt = '0;
                phase_nxt = ~phase;
            end else begin
                blink_nxt = blink_cnt + BW'(1);
            end
        end
    end

    logic       cnt_en_d, cnt_clr_d, cnt_dir_d, inc_min_d, inc_hour_d, last_hour_d;
    logic [3:0] mask_d;

    // Next values of the registered outputs, derived from the state being entered.
    always_comb begin
        cnt_en_d    = 1'b0;
        cnt_clr_d   = 1'b0;
        cnt_dir_d   = cnt_dir;
        inc_min_d   = 1'b0;
        inc_hour_d  = 1'b0;
        last_hour_d = last_hour;
        mask_d      = 4'h0;
        if (state == ST_RUN)
            cnt_en_d = tick_100hz && !expire;
        if ((state == ST_IDLE || state == ST_PAUSE) && rise_stop)
            cnt_clr_d = 1'b1;
        if ((state == ST_IDLE || state == ST_SET) && state_nxt == ST_RUN)
            cnt_dir_d = countdown_sw;
        if (state_nxt == ST_SET) begin
            inc_min_d  = rise_min || rep_min;
            inc_hour_d = rise_hour || rep_hour;
        end
        if (inc_hour_d)
            last_hour_d = 1'b1;
        else if (inc_min_d)
            last_hour_d = 1'b0;
        case (state_nxt)
            ST_SET:  if (phase_nxt) mask_d = last_hour_d ? field_bit(BLINK_HH) : field_bit(BLINK_MM);
            ST_DONE: if (phase_nxt) mask_d = BLINK_ALL;
            default: mask_d = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt    <= '0;
            alarm_cnt  <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            last_hour  <= 1'b0;
            cnt_en     <= 1'b0;
            cnt_dir    <= 1'b0;
            cnt_clr    <= 1'b0;
            inc_min    <= 1'b0;
            inc_hour   <= 1'b0;
            blink_mask <= 4'h0;
            alarm      <= 1'b0;
        end else begin
            if (state != ST_SET || tmo_clr)
                tmo_cnt <= '0;
            else if (tick_100hz)
                tmo_cnt <= tmo_cnt + TW'(1);
            if (state != ST_DONE)
                alarm_cnt <= '0;
            else if (tick_100hz)
                alarm_cnt <= alarm_cnt + AW'(1);
            blink_cnt  <= blink_nxt;
            phase      <= phase_nxt;
            last_hour  <= last_hour_d;
            cnt_en     <= cnt_en_d;
            cnt_dir    <= cnt_dir_d;
            cnt_clr    <= cnt_clr_d;
            inc_min    <= inc_min_d;
            inc_hour   <= inc_hour_d;
            blink_mask <= mask_d;
            alarm      <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode controller that sequences the stopwatch counter datapath from the debounced front-panel buttons and the countdown switch.
- Decides when the hh-mm-ss-xx counter advances and in which direction.
- Issues minute and hour set-increments, with press-and-hold auto-repeat.
- Detects countdown expiry and raises the alarm.
- Generates per-field blink masks for the display driver.
- Sits between the debounce instances / clock divider and the counter and display blocks.

Parameters:
REPEAT_DELAY, 50, 100 Hz ticks a set button is held before auto-repeat starts (0.5 s)
REPEAT_RATE, 10, ticks between auto-repeat increments (0.1 s)
SET_TIMEOUT, 1000, ticks without button activity in SET before returning to IDLE (10 s)
ALARM_TICKS, 300, ticks the alarm stays asserted in DONE (3 s)
BLINK_HALF, 50, ticks per blink half-period

Ports:
clk  in  1  100 MHz system clock
rst  in  1  synchronous, active-high reset
tick_100hz  in  1  single-clk strobe, one per 10 ms, from the clock divider
btn_start  in  1  debounced level
btn_stop  in  1  debounced level
btn_set_min  in  1  debounced level
btn_set_hour  in  1  debounced level
countdown_sw  in  1  slide switch level; 1 = countdown
time_zero  in  1  counter reads 00-00-00-00
cnt_en  out  1  one-clk strobe: advance counter by one centisecond
cnt_dir  out  1  0 = up, 1 = down
cnt_clr  out  1  one-clk strobe: clear counter to zero
inc_min  out  1  one-clk strobe: minutes +1 (datapath wraps 59->00)
inc_hour  out  1  one-clk strobe: hours +1 (datapath wraps 99->00)
state  out  3  current state encoding
blink_mask  out  4  bit0 xx, bit1 ss, bit2 mm, bit3 hh; 1 = blank that digit pair now
alarm  out  1  countdown-expired indicator

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE; all outputs 0.
  - Edge registers, hold/timeout/alarm/blink counters all 0.
  - Reset mid-RUN/SET/DONE aborts immediately; no cnt_clr is issued (the datapath has its own reset).
- Edge detect: rise_x = btn_x & ~btn_x_q, with btn_x_q registered each clk. All outputs are registered.
  - A button first sampled high at edge N produces its strobe/state change visible after edge N+1.
- State encoding: IDLE=0, RUN=1, PAUSE=2, SET=3, DONE=4. Codes 5-7 are illegal and go to IDLE next clk.
- IDLE:
  - rise_start: cnt_dir<=countdown_sw, go RUN. Exception: countdown_sw=1 and time_zero=1, then stay IDLE.
  - rise_set_min/rise_set_hour: emit inc_min/inc_hour, go SET.
  - rise_stop: emit cnt_clr.
- RUN:
  - On tick_100hz: if cnt_dir=1 and time_zero=1, go DONE with no cnt_en; otherwise cnt_en=1.
  - rise_stop: go PAUSE.
  - Set buttons are ignored.
  - cnt_dir is frozen; countdown_sw changes are ignored until the next IDLE->RUN.
  - Same-cycle expiry and rise_stop: DONE wins.
- PAUSE:
  - rise_start: go RUN, keeping cnt_dir.
  - rise_stop: emit cnt_clr, go IDLE.
  - Set rise: go SET with increment.
- SET:
  - rise_set_x: emit inc_x.
  - Holding exactly one set button: after REPEAT_DELAY ticks emit inc_x, then one every REPEAT_RATE ticks while held.
  - Releasing the button resets the hold counter.
  - rise_start: cnt_dir<=countdown_sw, go RUN, with the same time_zero/countdown guard as IDLE.
  - rise_stop: go IDLE, no clear.
  - Timeout counter counts ticks and is cleared by any button rise or active repeat. Reaching SET_TIMEOUT goes to IDLE.
- DONE:
  - alarm=1 on entry; alarm counter counts ticks.
  - Any button rise, or reaching ALARM_TICKS: alarm=0, go IDLE.
  - The counter stays at zero.
- Simultaneous rises:
  - start+stop in the same cycle: stop wins.
  - set_min+set_hour in the same cycle: both strobes in the same clk; auto-repeat is suppressed while both are held.
- Blink:
  - A phase bit toggles every BLINK_HALF ticks; the phase counter is cleared on every state change.
  - SET: blink_mask = phase ? the last-edited field (bit2 for min, bit3 for hour) : 0.
  - DONE: blink_mask = phase ? 4'hF : 0.
  - All other states: 0.
- Counters are sized ceil(log2(param+1)). All counters advance only on tick_100hz.

Decomposition:
- Shared package stopwatch_pkg:
  - state encoding constants (ST_IDLE..ST_DONE)
  - blink bit indices
  - tick-rate constant 100
- One sub-module is natural: hold_repeat (per-button hold counter plus auto-repeat strobe generator), instantiated twice for min and hour. Everything else stays in stopwatch_ctrl.

Test Plan:
1. Reset, then start pulse with countdown_sw=0, 5 ticks -> state=1, cnt_dir=0, exactly 5 cnt_en strobes each 1 clk after its tick.
2. RUN, stop, then stop -> state 1->2->0; exactly one cnt_clr strobe, on the second stop; no cnt_en while in PAUSE.
3. IDLE, hold btn_set_min for 80 ticks -> one immediate inc_min, repeats at ticks 50/60/70/80, total 5; blink_mask bit2 toggles every 50 ticks.
4. countdown_sw=1, start with time_zero=0, raise time_zero at tick 7 -> 6 cnt_en strobes with cnt_dir=1, then state=4, alarm=1; alarm clears after 300 ticks, state=0.
5. IDLE with countdown_sw=1 and time_zero=1, start pulse -> stays state=0, no cnt_en.
6. Start and stop rising in the same clk from PAUSE -> state=0 with cnt_clr. Also: rst asserted mid-SET while holding a button -> next clk state=0 and all outputs 0; no inc_min after rst releases until a new rise.
